// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: locks onto an incoming LFSR word stream, then counts
// word and bit errors against a locally free-running expected sequence.
module prbs16_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [15:0] inSeq,
  input  logic        clrCnt,
  output logic        locked,
  output logic        errFlag,
  output logic [15:0] wordErrCnt,
  output logic [23:0] bitErrCnt
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  state_t      state_q, state_d;
  logic [15:0] exp_q, exp_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [15:0] word_q, word_d;
  logic [23:0] bit_q, bit_d;
  logic [24:0] bit_sum_s;

  // The all-zero state is a lockup point of the LFSR, so it maps back to all-ones.
  function automatic logic [15:0] nxt(input logic [15:0] x);
    if (x == 16'h0000) begin
      return 16'hFFFF;
    end else begin
      return {x[14:0], x[15] ^ x[12] ^ x[11] ^ x[10]};
    end
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] x);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, x[i]};
    end
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    word_d    = word_q;
    bit_d     = bit_q;
    bit_sum_s = {1'b0, bit_q} + {20'd0, popcount16(inSeq ^ exp_q)};
    if (inValid) begin
      case (state_q)
        UNLOCKED: begin
          exp_d   = nxt(inSeq);
          match_d = 4'd0;
          state_d = LOCKING;
        end
        LOCKING: begin
          if (inSeq == exp_q) begin
            exp_d   = nxt(exp_q);
            match_d = match_q + 4'd1;
            if (match_d == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end else begin
              state_d = LOCKING;
            end
          end else begin
            exp_d   = nxt(inSeq);
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          // Once locked the received word never reseeds the expected sequence.
          exp_d = nxt(exp_q);
          if (inSeq == exp_q) begin
            miss_d = 4'd0;
          end else begin
            err_d  = 1'b1;
            word_d = (word_q == 16'hFFFF) ? 16'hFFFF : word_q + 16'd1;
            bit_d  = bit_sum_s[24] ? 24'hFFFFFF : bit_sum_s[23:0];
            miss_d = miss_q + 4'd1;
            if (miss_d == LOSS_C) begin
              state_d = UNLOCKED;
              match_d = 4'd0;
              miss_d  = 4'd0;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        default: begin
          state_d = UNLOCKED;
          match_d = 4'd0;
          miss_d  = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (clrCnt) begin
      word_d = 16'd0;
      bit_d  = 24'd0;
    end else begin
      word_d = word_d;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      exp_q    <= 16'hFFFF;
      match_q  <= 4'd0;
      miss_q   <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= 16'd0;
      bit_q    <= 24'd0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
    end
  end

  assign locked     = locked_q;
  assign errFlag    = err_q;
  assign wordErrCnt = word_q;
  assign bitErrCnt  = bit_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: lock, single/multi-bit errors, gaps,
// zero seed, LOCKING reseed, clear collision and reset.
module tb_prbs16_checker;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [15:0] inSeq;
  logic        clrCnt;
  logic        locked;
  logic        errFlag;
  logic [15:0] wordErrCnt;
  logic [23:0] bitErrCnt;

  int n_checks;
  int n_errors;
  logic [15:0] cur;

  prbs16_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .inValid    (inValid),
    .inSeq      (inSeq),
    .clrCnt     (clrCnt),
    .locked     (locked),
    .errFlag    (errFlag),
    .wordErrCnt (wordErrCnt),
    .bitErrCnt  (bitErrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    if (x == 16'h0000) begin
      return 16'hFFFF;
    end else begin
      return {x[14:0], x[15] ^ x[12] ^ x[11] ^ x[10]};
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; return 1 ns after the rising edge.
  task automatic step(input logic r, input logic v, input logic [15:0] w, input logic c);
    @(negedge clk);
    rst = r; inValid = v; inSeq = w; clrCnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_good();
    step(1'b0, 1'b1, cur, 1'b0);
    cur = lfsr_next(cur);
  endtask

  initial begin
    logic [15:0] seed_words [5];
    int gaps [3];
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; inValid = 1'b0; inSeq = 16'h0000; clrCnt = 1'b0;
    seed_words[0] = 16'hFFFF; seed_words[1] = 16'hFFFE; seed_words[2] = 16'hFFFC;
    seed_words[3] = 16'hFFF8; seed_words[4] = 16'hFFF0;
    gaps[0] = 1; gaps[1] = 3; gaps[2] = 5;

    step(1'b1, 1'b1, 16'h1234, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_err", {31'd0, errFlag}, 32'd0);
    check_eq("rst_word", {16'd0, wordErrCnt}, 32'd0);
    check_eq("rst_bit", {8'd0, bitErrCnt}, 32'd0);

    // Lock acquisition with the hand-derived sequence
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, seed_words[i], 1'b0);
      check_eq("acq_err", {31'd0, errFlag}, 32'd0);
      check_eq("acq_locked", {31'd0, locked}, (i == 4) ? 32'd1 : 32'd0);
    end
    cur = 16'hFFE0;

    // Single-bit error
    step(1'b0, 1'b1, cur ^ 16'h0001, 1'b0);
    cur = lfsr_next(cur);
    check_eq("sb_err", {31'd0, errFlag}, 32'd1);
    check_eq("sb_word", {16'd0, wordErrCnt}, 32'd1);
    check_eq("sb_bit", {8'd0, bitErrCnt}, 32'd1);
    check_eq("sb_locked", {31'd0, locked}, 32'd1);
    send_good();
    check_eq("sb_next_err", {31'd0, errFlag}, 32'd0);
    check_eq("sb_next_word", {16'd0, wordErrCnt}, 32'd1);
    check_eq("sb_next_locked", {31'd0, locked}, 32'd1);

    // Gaps with garbage on inSeq must change nothing
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < gaps[g]; k++) begin
        step(1'b0, 1'b0, 16'hDEAD, 1'b0);
        check_eq("gap_err", {31'd0, errFlag}, 32'd0);
        check_eq("gap_locked", {31'd0, locked}, 32'd1);
      end
      send_good();
      check_eq("gap_resume_err", {31'd0, errFlag}, 32'd0);
      check_eq("gap_resume_word", {16'd0, wordErrCnt}, 32'd1);
    end

    // Clear counters without a valid word
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("clr_word", {16'd0, wordErrCnt}, 32'd0);
    check_eq("clr_bit", {8'd0, bitErrCnt}, 32'd0);
    check_eq("clr_locked", {31'd0, locked}, 32'd1);

    // Three 8-bit errors: loss of lock on the third
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, cur ^ 16'h00FF, 1'b0);
      cur = lfsr_next(cur);
      check_eq("mb_err", {31'd0, errFlag}, 32'd1);
      check_eq("mb_word", {16'd0, wordErrCnt}, 32'(i + 1));
      check_eq("mb_bit", {8'd0, bitErrCnt}, 32'(8 * (i + 1)));
      check_eq("mb_locked", {31'd0, locked}, (i == 2) ? 32'd0 : 32'd1);
    end

    // Relock after LOCK_CNT+1 correct words
    for (int i = 0; i < 5; i++) begin
      send_good();
      check_eq("relock_err", {31'd0, errFlag}, 32'd0);
      check_eq("relock_locked", {31'd0, locked}, (i == 4) ? 32'd1 : 32'd0);
    end
    check_eq("relock_word_kept", {16'd0, wordErrCnt}, 32'd3);
    check_eq("relock_bit_kept", {8'd0, bitErrCnt}, 32'd24);

    // Clear colliding with a counted error
    step(1'b0, 1'b1, cur ^ 16'h0F00, 1'b1);
    cur = lfsr_next(cur);
    check_eq("coll_err", {31'd0, errFlag}, 32'd1);
    check_eq("coll_word", {16'd0, wordErrCnt}, 32'd0);
    check_eq("coll_bit", {8'd0, bitErrCnt}, 32'd0);
    send_good();
    check_eq("coll_next_err", {31'd0, errFlag}, 32'd0);
    check_eq("coll_next_locked", {31'd0, locked}, 32'd1);

    // Reset while locked with nonzero counters
    step(1'b0, 1'b1, cur ^ 16'h0001, 1'b0);
    cur = lfsr_next(cur);
    check_eq("pre_rst_word", {16'd0, wordErrCnt}, 32'd1);
    step(1'b1, 1'b1, cur ^ 16'h0003, 1'b0);
    check_eq("mid_rst_locked", {31'd0, locked}, 32'd0);
    check_eq("mid_rst_err", {31'd0, errFlag}, 32'd0);
    check_eq("mid_rst_word", {16'd0, wordErrCnt}, 32'd0);
    check_eq("mid_rst_bit", {8'd0, bitErrCnt}, 32'd0);

    // Zero word seeds FFFF; FFFF..FFF8 are then four matches
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    check_eq("zero_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, seed_words[i], 1'b0);
      check_eq("zero_locked_seq", {31'd0, locked}, (i == 3) ? 32'd1 : 32'd0);
    end

    // A mismatch in LOCKING reseeds silently from the received word
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    check_eq("reseed_err", {31'd0, errFlag}, 32'd0);
    check_eq("reseed_word", {16'd0, wordErrCnt}, 32'd0);
    cur = lfsr_next(16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      send_good();
      check_eq("reseed_locked", {31'd0, locked}, (i == 3) ? 32'd1 : 32'd0);
    end

    step(1'b0, 1'b0, 16'h0000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
